// File: rtl/tm_run_controller.sv
// Run controller for the Turing machine datapath: loads the transition table
// one nibble per Next press, then issues step pulses (manual or auto-rate)
// until the datapath halts. Done toggles between loading and running.
//
// Handshake: there is no valid/ready pairing here. prog_we and step are
// single-cycle strobes that the downstream logic must accept unconditionally
// in the cycle they are high.
module tm_run_controller #(
    parameter int DATA_W      = 4,
    parameter int TABLE_DEPTH = 64,
    parameter int RATE_W      = 16,
    localparam int AW         = $clog2(TABLE_DEPTH)
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              Next,
    input  logic              Done,
    input  logic              Auto,
    input  logic [RATE_W-1:0] rate,
    input  logic [DATA_W-1:0] input_data,
    input  logic              halted,
    output logic              prog_we,
    output logic [AW-1:0]     prog_addr,
    output logic [DATA_W-1:0] prog_wdata,
    output logic              step,
    output logic [1:0]        phase,
    output logic [15:0]       step_count,
    output logic              table_full
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [AW:0] LAST_ADDR = (AW+1)'(TABLE_DEPTH - 1);

    state_t            state, state_nxt;
    logic              next_q, done_q;
    logic [AW:0]       wptr, wptr_nxt;
    logic              full_nxt;
    logic              we_nxt;
    logic [AW-1:0]     addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              step_nxt;
    logic [15:0]       count_nxt;
    logic [RATE_W-1:0] rate_cnt, rate_cnt_nxt;
    logic              next_rise, done_rise;

    assign next_rise = Next & ~next_q;
    assign done_rise = Done & ~done_q;
    assign phase     = state;

    // State and registered outputs; everything resets to zero / LOAD.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state      <= LOAD;
            next_q     <= 1'b0;
            done_q     <= 1'b0;
            wptr       <= '0;
            table_full <= 1'b0;
            prog_we    <= 1'b0;
            prog_addr  <= '0;
            prog_wdata <= '0;
            step       <= 1'b0;
            step_count <= '0;
            rate_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            next_q     <= Next;
            done_q     <= Done;
            wptr       <= wptr_nxt;
            table_full <= full_nxt;
            prog_we    <= we_nxt;
            prog_addr  <= addr_nxt;
            prog_wdata <= wdata_nxt;
            step       <= step_nxt;
            step_count <= count_nxt;
            rate_cnt   <= rate_cnt_nxt;
        end
    end

    // Next-state: table writes in LOAD, step generation in RUN. Done beats
    // halted, and halted beats any due step.
    always_comb begin
        state_nxt    = state;
        wptr_nxt     = wptr;
        full_nxt     = table_full;
        we_nxt       = 1'b0;
        addr_nxt     = prog_addr;
        wdata_nxt    = prog_wdata;
        step_nxt     = 1'b0;
        count_nxt    = step_count;
        rate_cnt_nxt = rate_cnt;
        unique case (state)
            LOAD: begin
                if (next_rise && !table_full) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = wptr[AW-1:0];
                    wdata_nxt = input_data;
                    wptr_nxt  = wptr + 1'b1;
                    if (wptr == LAST_ADDR) full_nxt = 1'b1;
                end
                if (done_rise) begin
                    state_nxt    = RUN;
                    rate_cnt_nxt = rate;
                end
            end
            RUN: begin
                if (done_rise) begin
                    state_nxt = LOAD;
                    wptr_nxt  = '0;
                    full_nxt  = 1'b0;
                    count_nxt = '0;
                end else if (halted) begin
                    state_nxt = HALT;
                end else if (Auto) begin
                    if (rate_cnt == '0) begin
                        step_nxt     = 1'b1;
                        rate_cnt_nxt = rate;
                        if (step_count != 16'hFFFF) count_nxt = step_count + 16'd1;
                    end else begin
                        rate_cnt_nxt = rate_cnt - 1'b1;
                    end
                end else if (next_rise) begin
                    step_nxt = 1'b1;
                    if (step_count != 16'hFFFF) count_nxt = step_count + 16'd1;
                end
            end
            HALT: begin
                if (done_rise) begin
                    state_nxt = LOAD;
                    wptr_nxt  = '0;
                    full_nxt  = 1'b0;
                    count_nxt = '0;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

endmodule

// File: tb/tb_tm_run_controller.sv
module tb_tm_run_controller;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Next = 1'b0, Done = 1'b0, Auto = 1'b0, halted = 1'b0;
    logic [15:0] rate = 16'd3;
    logic [3:0]  input_data = 4'd0;
    logic        prog_we, step, table_full;
    logic [5:0]  prog_addr;
    logic [3:0]  prog_wdata;
    logic [1:0]  phase;
    logic [15:0] step_count;

    always #5 clock = ~clock;

    tm_run_controller dut (
        .clock(clock), .Reset(Reset), .Next(Next), .Done(Done), .Auto(Auto),
        .rate(rate), .input_data(input_data), .halted(halted),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
        .step(step), .phase(phase), .step_count(step_count), .table_full(table_full)
    );

    int compared = 0;
    int mismatched = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic we, input logic [5:0] addr,
                             input logic [3:0] wd, input logic stp, input logic [1:0] ph,
                             input logic [15:0] cnt, input logic full);
        check({tag, ".prog_we"},    32'(prog_we),    32'(we));
        check({tag, ".prog_addr"},  32'(prog_addr),  32'(addr));
        check({tag, ".prog_wdata"}, 32'(prog_wdata), 32'(wd));
        check({tag, ".step"},       32'(step),       32'(stp));
        check({tag, ".phase"},      32'(phase),      32'(ph));
        check({tag, ".step_count"}, 32'(step_count), 32'(cnt));
        check({tag, ".table_full"}, 32'(table_full), 32'(full));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       nx, dn, au, hl;
        logic [3:0] din;
        logic       we;
        logic [5:0] addr;
        logic [3:0] wd;
        logic       stp;
        logic [1:0] ph;
        logic [15:0] cnt;
        logic       full;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic nx, dn, au, hl, input logic [3:0] din,
                       input logic we, input logic [5:0] addr, input logic [3:0] wd,
                       input logic stp, input logic [1:0] ph, input logic [15:0] cnt);
        vec_t v;
        v.nx = nx; v.dn = dn; v.au = au; v.hl = hl; v.din = din;
        v.we = we; v.addr = addr; v.wd = wd; v.stp = stp; v.ph = ph; v.cnt = cnt;
        v.full = 1'b0;
        vecs.push_back(v);
    endtask

    initial begin
        //   nx dn au hl din   we addr wd  stp ph cnt
        // load 3 entries, each Next held two cycles
        add(1, 0, 0, 0, 4'd3, 1, 0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 4'd3, 0, 0, 3, 0, 0, 0);
        add(0, 0, 0, 0, 4'd9, 0, 0, 3, 0, 0, 0);
        add(1, 0, 0, 0, 4'd1, 1, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 4'd1, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 4'd9, 0, 1, 1, 0, 0, 0);
        add(1, 0, 0, 0, 4'd2, 1, 2, 2, 0, 0, 0);
        add(1, 0, 0, 0, 4'd2, 0, 2, 2, 0, 0, 0);
        add(0, 0, 0, 0, 4'd9, 0, 2, 2, 0, 0, 0);
        // Done rise -> RUN, held Done gives one rise only
        add(0, 1, 0, 0, 4'd9, 0, 2, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'd9, 0, 2, 2, 0, 1, 0);
        // four manual steps
        add(1, 0, 0, 0, 4'd9, 0, 2, 2, 1, 1, 1);
        add(0, 0, 0, 0, 4'd9, 0, 2, 2, 0, 1, 1);
        add(1, 0, 0, 0, 4'd9, 0, 2, 2, 1, 1, 2);
        add(1, 0, 0, 0, 4'd9, 0, 2, 2, 0, 1, 2);
        add(0, 0, 0, 0, 4'd9, 0, 2, 2, 0, 1, 2);
        add(1, 0, 0, 0, 4'd9, 0, 2, 2, 1, 1, 3);
        add(0, 0, 0, 0, 4'd9, 0, 2, 2, 0, 1, 3);
        add(1, 0, 0, 0, 4'd9, 0, 2, 2, 1, 1, 4);
        // halt, then Next is ignored
        add(0, 0, 0, 1, 4'd9, 0, 2, 2, 0, 2, 4);
        add(1, 0, 0, 1, 4'd9, 0, 2, 2, 0, 2, 4);
        add(0, 0, 0, 0, 4'd9, 0, 2, 2, 0, 2, 4);
        add(1, 0, 0, 0, 4'd9, 0, 2, 2, 0, 2, 4);
        // Done in HALT -> LOAD, counters cleared, next write at addr 0
        add(0, 1, 0, 0, 4'd9, 0, 2, 2, 0, 0, 0);
        add(1, 0, 0, 0, 4'd5, 1, 0, 5, 0, 0, 0);
        add(0, 0, 0, 0, 4'd9, 0, 0, 5, 0, 0, 0);
        // Next and Done rise together: write + RUN at the same edge
        add(1, 1, 0, 0, 4'd6, 1, 1, 6, 0, 1, 0);
        add(0, 0, 0, 0, 4'd9, 0, 1, 6, 0, 1, 0);
        // Done in RUN -> LOAD
        add(0, 1, 0, 0, 4'd9, 0, 1, 6, 0, 0, 0);
        add(0, 0, 0, 0, 4'd9, 0, 1, 6, 0, 0, 0);
    end

    // ---------------- main sequence ----------------
    initial begin
        #1;
        // reset state
        tick();
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        #2 Reset = 1'b0;
        tick();
        check_all("post_reset", 0, 0, 0, 0, 0, 0, 0);

        // table-driven section
        for (int i = 0; i < vecs.size(); i++) begin
            Next = vecs[i].nx; Done = vecs[i].dn; Auto = vecs[i].au;
            halted = vecs[i].hl; input_data = vecs[i].din;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wd,
                      vecs[i].stp, vecs[i].ph, vecs[i].cnt, vecs[i].full);
        end

        // fill the table: 65 rises, 64 writes, last ignored
        Reset = 1'b1; #2 Reset = 1'b0;
        Next = 0; Done = 0; Auto = 0; halted = 0;
        tick();
        for (int i = 0; i < 65; i++) begin
            Next = 1'b1; input_data = 4'(i);
            tick();
            if (i < 64) begin
                check($sformatf("fill%0d.we", i),   32'(prog_we),   32'd1);
                check($sformatf("fill%0d.addr", i), 32'(prog_addr), 32'(i));
                check($sformatf("fill%0d.data", i), 32'(prog_wdata), 32'(i & 15));
            end else begin
                check("fill64.we", 32'(prog_we), 32'd0);
                check("fill64.addr_held", 32'(prog_addr), 32'd63);
            end
            check($sformatf("fill%0d.full", i), 32'(table_full), 32'(i >= 63));
            Next = 1'b0;
            tick();
            check($sformatf("fill%0d.we_low", i), 32'(prog_we), 32'd0);
        end

        // auto run, rate=3: first step 4 edges after entry
        Auto = 1'b1; rate = 16'd3;
        Done = 1'b1;
        tick();
        check("auto_entry.phase", 32'(phase), 32'd1);
        check("auto_entry.step", 32'(step), 32'd0);
        Done = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("auto3_%0d.step", k), 32'(step), 32'(k % 4 == 0));
            check($sformatf("auto3_%0d.count", k), 32'(step_count), 32'(k / 4));
        end
        // rate change applies at the next reload (edge 16), then every cycle
        rate = 16'd0;
        for (int k = 13; k <= 20; k++) begin
            tick();
            check($sformatf("auto0_%0d.step", k), 32'(step), 32'(k >= 16));
            check($sformatf("auto0_%0d.count", k), 32'(step_count), 32'(k >= 16 ? k - 12 : 3));
        end
        // halted on a due edge suppresses the step
        halted = 1'b1;
        tick();
        check("halt_due.step", 32'(step), 32'd0);
        check("halt_due.phase", 32'(phase), 32'd2);
        check("halt_due.count", 32'(step_count), 32'd8);
        tick();
        check("halt_hold.step", 32'(step), 32'd0);
        check("halt_hold.phase", 32'(phase), 32'd2);

        // reset during an auto step pulse
        halted = 1'b0;
        Done = 1'b1; tick(); Done = 1'b0; tick();
        check("relead.phase", 32'(phase), 32'd0);
        Done = 1'b1; tick();
        check("rerun.phase", 32'(phase), 32'd1);
        Done = 1'b0; tick();
        check("rerun.step", 32'(step), 32'd1);
        Reset = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        #1 Reset = 1'b0;
        Auto = 1'b0; Next = 1'b1; input_data = 4'd7;
        tick();
        check_all("after_reset_write", 1, 0, 7, 0, 0, 0, 0);
        Next = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tm_run_controller.md
# tm_run_controller

Sequencer in front of the Turing machine datapath. It loads the transition table, one nibble per `Next` press, into the table memory. After `Done` it switches to execution and issues one-cycle `step` pulses to the datapath, either manually (one per `Next` press) or automatically at a programmable rate. It stops when the datapath reports the halt state.

## Interface
Parameters:
- `DATA_W`, 4, width of one program entry / `input_data`
- `TABLE_DEPTH`, 64, number of transition-table entries; `AW = $clog2(TABLE_DEPTH)`
- `RATE_W`, 16, width of auto-step interval

Ports:
- `clock`  in  1  system clock, all logic on rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Next`  in  1  level; rising edge = enter entry (LOAD) or request step (RUN, manual)
- `Done`  in  1  level; rising edge = end load / return to load
- `Auto`  in  1  1 = free-run stepping in RUN, 0 = manual
- `rate`  in  RATE_W  auto-step interval minus 1, in cycles
- `input_data`  in  DATA_W  program entry to write
- `halted`  in  1  datapath is in halt state
- `prog_we`  out  1  one-cycle table write strobe
- `prog_addr`  out  AW  table address for current write
- `prog_wdata`  out  DATA_W  table write data
- `step`  out  1  one-cycle step pulse to datapath
- `phase`  out  2  0 = LOAD, 1 = RUN, 2 = HALT (3 unused)
- `step_count`  out  16  steps issued since last LOAD entry, saturating
- `table_full`  out  1  all TABLE_DEPTH entries written

## Operation
- **Inputs and edge detect.** `Next` and `Done` are synchronous to `clock`. Each is registered once (`next_q`, `done_q`). A rise is `X & ~X_q`, evaluated at a clock edge. A held level produces exactly one rise.
- **Reset values.** Phase = LOAD. Write pointer = 0. All outputs = 0. `next_q` and `done_q` = 0.
- **LOAD.** On a `Next` rise while `table_full`=0:
  - register `prog_we`=1, `prog_addr`=write pointer, `prog_wdata`=`input_data`;
  - write pointer += 1;
  - if the written address = TABLE_DEPTH-1, set `table_full`=1.
- **LOAD, table full.** `Next` rises are ignored; no `prog_we`.
- **LOAD to RUN.** A `Done` rise moves to RUN and loads the rate counter with `rate`. An empty table is allowed.
- **Next and Done rise on the same edge in LOAD.** The write is performed and the transition to RUN also occurs.
- **RUN, `Auto`=0.** Each `Next` rise registers `step`=1 for one cycle; `step_count` += 1.
- **RUN, `Auto`=1.** `Next` is ignored. Each edge:
  - if the rate counter = 0: register `step`=1, `step_count` += 1, reload counter with `rate`;
  - otherwise decrement the counter.
- **RUN, rate counter with `Auto`=0.** The counter holds its value.
- **`halted` in RUN.** `halted`=1 sampled at an edge moves to HALT. No step is issued at that edge, even if one was due.
- **RUN or HALT, `Done` rise.** Return to LOAD: clear write pointer, `table_full` and `step_count`. No step is issued at that edge. In RUN, `Done` has priority over `halted` and over any step.
- **HALT.** No steps are issued; `Next` and `Auto` are ignored. Only `Done` leaves HALT.
- **Arithmetic.**
  - `step_count` saturates at 16'hFFFF.
  - The write pointer is AW+1 bits internally, so no wrap occurs at TABLE_DEPTH.
  - A `rate` change takes effect at the next reload.
- **`prog_we` and `step` deassertion.** Both are 0 in every cycle not explicitly pulsed.

## Timing
- **Write latency.** A `Next` rise sampled at edge E gives `prog_we`/`prog_addr`/`prog_wdata` valid during the cycle after E only.
- **Manual step latency.** A `Next` rise sampled at edge E gives `step`=1 during the cycle after E. `step_count` updates at E.
- **Auto stepping.** After entry to RUN at edge E0, the first step is registered at edge E0+rate+1. Steps then follow every rate+1 cycles; `rate`=0 gives a step every cycle.
- **Phase timing.** `phase` is registered and changes at the edge that samples the causing event.
- **Asynchronous reset.** Asserting `Reset` at any time, including mid-pulse, drops `step` and `prog_we` immediately and forces the reset values.

## Test plan
- **Load 3 entries.** Reset, then `Next` pulses with `input_data`=3, 1, 2 (each held 2 cycles) -> exactly three `prog_we` pulses at addr 0/1/2 with data 3/1/2; `phase`=0; `table_full`=0.
- **Fill the table.** With TABLE_DEPTH=64, issue 65 `Next` rises -> 64 writes (addr 0..63); `table_full`=1 after the 64th; 65th produces no `prog_we`.
- **Manual run.** `Done` rise -> `phase`=1. Four `Next` rises with `Auto`=0 -> four single-cycle `step` pulses; `step_count`=4. Raise `halted` -> `phase`=2; further `Next` gives no `step`.
- **Auto run.** `Auto`=1, `rate`=3 -> `step` every 4 cycles, first at 4 edges after RUN entry. `rate`=0 -> `step` every cycle. `halted` asserted on a due edge -> no step, `phase`=2.
- **Simultaneous events.** `Next` and `Done` rise together in LOAD -> entry written and `phase`=1 at the same edge. `Done` rise in HALT -> `phase`=0, `step_count`=0, next write at addr 0.
- **Reset mid-operation.** Assert `Reset` asynchronously during an auto-run `step` pulse -> `step`=0 immediately, `phase`=0, all counters 0.
